// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : Command strobe, PS/2 line sense/drive and status signals
//                shared between the host transmitter and its user.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_host_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       ps2c_in;
    logic       ps2d_in;
    logic       ps2c_oe;
    logic       ps2d_oe;
    logic       tx_idle;
    logic       rx_inhibit;
    logic       tx_done_tick;
    logic       tx_err;

    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, tx_idle, rx_inhibit, tx_done_tick, tx_err
    );

    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, tx_idle, rx_inhibit, tx_done_tick, tx_err
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : Host-to-device PS/2 transmitter; sends one command byte to
//                the keyboard over the open-collector ps2c/ps2d lines.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx #(
    parameter int RTS_CYCLES     = 12000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  wire logic    clk,
    input  wire logic    Reset,
    ps2_host_tx_if.slave bus
);

    localparam int c_fw = $clog2(FILTER_LEN + 1);
    localparam int c_rw = $clog2(RTS_CYCLES + 1);
    localparam int c_ww = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [c_fw-1:0] c_flt_last  = c_fw'(FILTER_LEN - 1);
    localparam logic [c_rw-1:0] c_rts_last  = c_rw'(RTS_CYCLES - 1);
    localparam logic [c_ww-1:0] c_tmo       = c_ww'(TIMEOUT_CYCLES);
    localparam logic [3:0]      c_last_data = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RTS      = 3'd1,
        S_START    = 3'd2,
        S_DATA     = 3'd3,
        S_ACK      = 3'd4,
        S_WAIT_REL = 3'd5
    } state_t;

    // index 0 = clock line, index 1 = data line
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    assign w_raw = {bus.ps2d_in, bus.ps2c_in};

    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic            r_s1;
        logic            r_s2;
        logic            r_filt;
        logic [c_fw-1:0] r_fcnt;

        always_ff @(posedge clk) begin
            if (!Reset) begin
                r_s1   <= 1'b1;
                r_s2   <= 1'b1;
                r_filt <= 1'b1;
                r_fcnt <= '0;
            end else begin
                r_s1 <= w_raw[i];
                r_s2 <= r_s1;
                if (r_s2 == r_filt) begin
                    r_fcnt <= '0;
                end else if (r_fcnt == c_flt_last) begin
                    r_filt <= r_s2;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + c_fw'(1);
                end
            end
        end

        assign w_filt[i] = r_filt;
    end

    state_t          r_state, w_state_n;
    logic [8:0]      r_sh, w_sh_n;
    logic [3:0]      r_n, w_n_n;
    logic [c_rw-1:0] r_rts, w_rts_n;
    logic [c_ww-1:0] r_wd, w_wd_n;
    logic            r_dbit, w_dbit_n;
    logic            r_c_prev;
    logic            r_c_oe, r_d_oe, r_idle;
    logic            w_fall, w_busy, w_done, w_err;

    assign w_fall = r_c_prev & ~w_filt[0];
    assign w_busy = (r_state == S_START) || (r_state == S_DATA) ||
                    (r_state == S_ACK)   || (r_state == S_WAIT_REL);

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state  <= S_IDLE;
            r_sh     <= '0;
            r_n      <= '0;
            r_rts    <= '0;
            r_wd     <= '0;
            r_dbit   <= 1'b0;
            r_c_prev <= 1'b1;
            r_c_oe   <= 1'b0;
            r_d_oe   <= 1'b0;
            r_idle   <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_sh     <= w_sh_n;
            r_n      <= w_n_n;
            r_rts    <= w_rts_n;
            r_wd     <= w_wd_n;
            r_dbit   <= w_dbit_n;
            r_c_prev <= w_filt[0];
            // line enables registered from the next state so they never glitch
            r_c_oe   <= (w_state_n == S_RTS);
            r_d_oe   <= (w_state_n == S_START) || ((w_state_n == S_DATA) && w_dbit_n);
            r_idle   <= (w_state_n == S_IDLE);
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_sh_n    = r_sh;
        w_n_n     = r_n;
        w_rts_n   = r_rts;
        w_wd_n    = w_busy ? (r_wd + c_ww'(1)) : '0;
        w_dbit_n  = r_dbit;
        w_done    = 1'b0;
        w_err     = 1'b0;

        if (w_busy && (r_wd == c_tmo)) begin
            w_err     = 1'b1;
            w_state_n = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.wr_ps2) begin
                        w_sh_n    = {~^bus.din, bus.din};
                        w_n_n     = '0;
                        w_rts_n   = '0;
                        w_state_n = S_RTS;
                    end
                end
                S_RTS: begin
                    if (r_rts == c_rts_last) begin
                        w_state_n = S_START;
                    end else begin
                        w_rts_n = r_rts + c_rw'(1);
                    end
                end
                S_START: begin
                    if (w_fall) begin
                        w_dbit_n  = ~r_sh[0];
                        w_sh_n    = {1'b0, r_sh[8:1]};
                        w_n_n     = 4'd1;
                        w_state_n = S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_fall) begin
                        w_n_n = r_n + 4'd1;
                        if (r_n == c_last_data) begin
                            w_dbit_n  = 1'b0;
                            w_state_n = S_ACK;
                        end else begin
                            w_dbit_n = ~r_sh[0];
                            w_sh_n   = {1'b0, r_sh[8:1]};
                        end
                    end
                end
                S_ACK: begin
                    if (w_fall) begin
                        w_n_n = r_n + 4'd1;
                        if (!w_filt[1]) begin
                            w_state_n = S_WAIT_REL;
                        end else begin
                            w_err     = 1'b1;
                            w_state_n = S_IDLE;
                        end
                    end
                end
                S_WAIT_REL: begin
                    if (w_filt[0] && w_filt[1]) begin
                        w_done    = 1'b1;
                        w_state_n = S_IDLE;
                    end
                end
                default: w_state_n = S_IDLE;
            endcase
        end
    end

    assign bus.ps2c_oe      = r_c_oe;
    assign bus.ps2d_oe      = r_d_oe;
    assign bus.tx_idle      = r_idle;
    assign bus.rx_inhibit   = ~r_idle;
    assign bus.tx_done_tick = w_done;
    assign bus.tx_err       = w_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Bench for ps2_host_tx with a PS/2 device model and a queue of
//                expected outcomes checked whenever done/err pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;

    logic clk = 1'b0;
    logic Reset;
    logic dev_c = 1'b1;
    logic dev_d = 1'b1;

    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    assign bus.ps2c_in = ~bus.ps2c_oe & dev_c;
    assign bus.ps2d_in = ~bus.ps2d_oe & dev_d;

    ps2_host_tx #(
        .RTS_CYCLES     (20),
        .TIMEOUT_CYCLES (5000),
        .FILTER_LEN     (4)
    ) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] din;
        bit         err;
        bit         chk;
    } exp_t;

    exp_t        q[$];
    exp_t        e_mon;
    logic [10:0] cap;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Line bits as the device should see them: start, d0..d7, odd parity, stop
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    always @(negedge clk) begin
        if (Reset === 1'b1 && (bus.tx_done_tick || bus.tx_err)) begin
            check("done_err_exclusive", {31'd0, bus.tx_done_tick & bus.tx_err}, 0);
            check("idle_during_pulse", {31'd0, bus.tx_idle}, 0);
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_pulse: got done=%0b err=%0b, expected none",
                         bus.tx_done_tick, bus.tx_err);
            end else begin
                e_mon = q.pop_front();
                check("pulse_is_err", {31'd0, bus.tx_err}, {31'd0, e_mon.err});
                if (e_mon.chk) check("frame_bits", {21'd0, cap}, {21'd0, frame_of(e_mon.din)});
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit err, input bit chk, input bit push);
        @(negedge clk);
        bus.wr_ps2 = 1'b1;
        bus.din    = d;
        if (push) q.push_back('{d, err, chk});
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'($urandom);
        check("busy_after_accept", {31'd0, bus.tx_idle}, 0);
    endtask

    task automatic stray_strobe();
        repeat (300) @(negedge clk);
        bus.wr_ps2 = 1'b1;
        bus.din    = 8'hFF;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        check("busy_after_stray", {31'd0, bus.tx_idle}, 0);
    endtask

    // Device side: measures RTS, then clocks the frame in (or stays silent)
    task automatic device(input bit silent, input bit ack, input int reset_at);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.ps2c_oe && t < 100) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (bus.ps2c_oe && t < 1000) begin
            t++;
            @(negedge clk);
        end
        check("rts_len", t, 20);
        if (silent) begin
            check("start_bit_drive", {31'd0, bus.ps2d_oe}, 1);
            t = 0;
            while (!bus.tx_err && t < 6000) begin
                @(negedge clk);
                t++;
            end
            check("timeout_cycles", t, 5000);
            @(negedge clk);
            check("tmo_oe_released", {30'd0, bus.ps2c_oe, bus.ps2d_oe}, 0);
            check("tmo_rx_inhibit", {31'd0, bus.rx_inhibit}, 0);
            return;
        end
        repeat (10) @(negedge clk);
        cap    = '1;
        cap[0] = bus.ps2d_in;
        for (int k = 1; k <= 11; k++) begin
            dev_c = 1'b0;
            repeat (30) @(negedge clk);
            if (k == reset_at) begin
                Reset = 1'b0;
                @(negedge clk);
                Reset = 1'b1;
                check("rst_oe_released", {30'd0, bus.ps2c_oe, bus.ps2d_oe}, 0);
                check("rst_idle", {31'd0, bus.tx_idle}, 1);
                check("rst_rx_inhibit", {31'd0, bus.rx_inhibit}, 0);
                dev_c = 1'b1;
                dev_d = 1'b1;
                return;
            end
            if (k <= 10) cap[k] = bus.ps2d_in;
            repeat (10) @(negedge clk);
            dev_c = 1'b1;
            repeat (20) @(negedge clk);
            if (k == 10) dev_d = ~ack;
            repeat (20) @(negedge clk);
        end
        dev_d = 1'b1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (!bus.tx_idle && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("back_to_idle", {31'd0, bus.tx_idle}, 1);
        repeat (50) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        bit         ack;
        Reset      = 1'b0;
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        repeat (5) @(negedge clk);
        check("reset_idle", {31'd0, bus.tx_idle}, 1);
        check("reset_oe", {30'd0, bus.ps2c_oe, bus.ps2d_oe}, 0);
        check("reset_rx_inhibit", {31'd0, bus.rx_inhibit}, 0);
        check("reset_pulses", {30'd0, bus.tx_done_tick, bus.tx_err}, 0);
        Reset = 1'b1;
        repeat (10) @(negedge clk);

        fork send(8'hED, 1'b0, 1'b1, 1'b1); device(1'b0, 1'b1, 0); join
        wait_idle();
        fork send(8'hF4, 1'b0, 1'b1, 1'b1); device(1'b0, 1'b1, 0); join
        wait_idle();
        fork send(8'($urandom), 1'b1, 1'b0, 1'b1); device(1'b1, 1'b0, 0); join
        wait_idle();
        fork send(8'h5A, 1'b1, 1'b1, 1'b1); device(1'b0, 1'b0, 0); join
        wait_idle();
        fork send(8'hED, 1'b0, 1'b1, 1'b1); device(1'b0, 1'b1, 0); stray_strobe(); join
        wait_idle();
        fork send(8'h00, 1'b0, 1'b0, 1'b0); device(1'b0, 1'b1, 5); join
        repeat (30) @(negedge clk);
        fork send(8'hED, 1'b0, 1'b1, 1'b1); device(1'b0, 1'b1, 0); join
        wait_idle();

        for (int i = 0; i < 10; i++) begin
            d   = 8'($urandom);
            ack = ($urandom_range(0, 3) != 0);
            fork send(d, !ack, 1'b1, 1'b1); device(1'b0, ack, 0); join
            wait_idle();
        end

        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
